// File: rtl/varredura_display_if.sv
// varredura_display_if -- bus between a number source and the display scanner.
//
// Signals:
//   carregar  single-cycle strobe; capture sinal and the digits below
//   sinal     sign of the number (1 = negative)
//   milhar, centena, dezena, unidade   BCD digits (values 10-15 are shown blank)
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   anodo     position enables, active-low (0 unidade .. 3 milhar, 4 sign)
//   quadro    one-cycle pulse after each complete 5-position scan
//
// Modports:
//   master  side that supplies numbers and observes the display
//   slave   the scanner itself
interface varredura_display_if;
  logic       carregar;
  logic       sinal;
  logic [3:0] milhar;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic [6:0] seg;
  logic [4:0] anodo;
  logic       quadro;

  modport master (
    output carregar, sinal, milhar, centena, dezena, unidade,
    input  seg, anodo, quadro
  );

  modport slave (
    input  carregar, sinal, milhar, centena, dezena, unidade,
    output seg, anodo, quadro
  );
endinterface

// File: rtl/varredura_display.sv
// varredura_display -- multiplexed scanner for a signed 4-digit 7-segment display.
//
// Each of the five positions (unidade, dezena, centena, milhar, sign) is lit
// for DIVISOR clock cycles in turn. A number captured with carregar waits in a
// pending register and is copied to the displayed (shadow) register only when
// a full scan completes, so a frame never mixes digits of two numbers.
//
// Parameters:
//   DIVISOR   clock cycles each position stays lit (2 .. 2**20)
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous, active-high reset
//   bus       varredura_display_if.slave (carregar/sinal/digits in; seg/anodo/quadro out)
//
// Build option:
//   SUPRESSAO_ZEROS_EN  when defined, leading zero digits are blanked
//                       (unidade is never blanked; anodo still strobes them)
//
// Position FSM:
//   state        | meaning
//   POS_UNIDADE  | unidade digit lit (anodo bit 0)
//   POS_DEZENA   | dezena digit lit (anodo bit 1)
//   POS_CENTENA  | centena digit lit (anodo bit 2)
//   POS_MILHAR   | milhar digit lit (anodo bit 3)
//   POS_SINAL    | sign position lit (anodo bit 4); leaving it ends the scan
module varredura_display #(
  parameter int DIVISOR = 50000
) (
  input  logic clock,
  input  logic reset,
  varredura_display_if.slave bus
);

  localparam int PRE_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIVISOR - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [4:0] AN_OFF    = 5'b11111;

  generate
    if (DIVISOR < 2 || DIVISOR > (1 << 20)) begin : g_bad_divisor
      $error("varredura_display: DIVISOR out of range 2..2**20");
    end
  endgenerate

  typedef enum logic [2:0] {
    POS_UNIDADE = 3'd0,
    POS_DEZENA  = 3'd1,
    POS_CENTENA = 3'd2,
    POS_MILHAR  = 3'd3,
    POS_SINAL   = 3'd4
  } pos_t;

  typedef struct packed {
    logic       sinal;
    logic [3:0] milhar;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
  } numero_t;

  logic [PRE_W-1:0] prescaler;
  logic             avanca;
  logic             fim_varredura;

  pos_t             pos;
  pos_t             pos_next;

  numero_t          pendente;
  logic             pendente_ok;
  numero_t          sombra;

  logic             zero_milhar;
  logic             zero_centena;
  logic             zero_dezena;

  logic [3:0]       digito;
  logic             apaga;
  logic [6:0]       seg_next;
  logic [4:0]       anodo_next;

  logic [6:0]       seg_q;
  logic [4:0]       anodo_q;
  logic             quadro_q;

  function automatic logic [6:0] bcd_para_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Prescaler: counts 0..DIVISOR-1; the terminal count moves the position.
  assign avanca        = (prescaler == PRE_LAST);
  assign fim_varredura = avanca && (pos == POS_SINAL);

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
    end else if (avanca) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos <= POS_UNIDADE;
    end else begin
      pos <= pos_next;
    end
  end

  always_comb begin
    pos_next = pos;
    if (avanca) begin
      case (pos)
        POS_UNIDADE: pos_next = POS_DEZENA;
        POS_DEZENA:  pos_next = POS_CENTENA;
        POS_CENTENA: pos_next = POS_MILHAR;
        POS_MILHAR:  pos_next = POS_SINAL;
        POS_SINAL:   pos_next = POS_UNIDADE;
        default:     pos_next = POS_UNIDADE;
      endcase
    end
  end

  // Pending/shadow pair. On the scan-end edge the shadow takes whatever was
  // pending before that edge; a strobe on the same edge refills pending and
  // keeps the flag set so it is shown after the following scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      pendente    <= '0;
      pendente_ok <= 1'b0;
      sombra      <= '0;
    end else begin
      if (fim_varredura && pendente_ok) begin
        sombra <= pendente;
      end
      if (bus.carregar) begin
        pendente    <= '{sinal:   bus.sinal,
                         milhar:  bus.milhar,
                         centena: bus.centena,
                         dezena:  bus.dezena,
                         unidade: bus.unidade};
        pendente_ok <= 1'b1;
      end else if (fim_varredura && pendente_ok) begin
        pendente_ok <= 1'b0;
      end
    end
  end

  // A digit is a leading zero only if it and every more-significant digit is 0.
`ifdef SUPRESSAO_ZEROS_EN
  assign zero_milhar  = (sombra.milhar == 4'd0);
  assign zero_centena = zero_milhar && (sombra.centena == 4'd0);
  assign zero_dezena  = zero_centena && (sombra.dezena == 4'd0);
`else
  assign zero_milhar  = 1'b0;
  assign zero_centena = 1'b0;
  assign zero_dezena  = 1'b0;
`endif

  always_comb begin
    digito     = 4'd0;
    apaga      = 1'b0;
    seg_next   = SEG_BLANK;
    anodo_next = AN_OFF;
    case (pos)
      POS_UNIDADE: begin
        anodo_next = 5'b11110;
        digito     = sombra.unidade;
      end
      POS_DEZENA: begin
        anodo_next = 5'b11101;
        digito     = sombra.dezena;
        apaga      = zero_dezena;
      end
      POS_CENTENA: begin
        anodo_next = 5'b11011;
        digito     = sombra.centena;
        apaga      = zero_centena;
      end
      POS_MILHAR: begin
        anodo_next = 5'b10111;
        digito     = sombra.milhar;
        apaga      = zero_milhar;
      end
      POS_SINAL: begin
        anodo_next = 5'b01111;
      end
      default: begin
        anodo_next = AN_OFF;
      end
    endcase

    if (pos == POS_SINAL) begin
      seg_next = sombra.sinal ? SEG_MINUS : SEG_BLANK;
    end else if (apaga) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = bcd_para_seg(digito);
    end
  end

  // Registered outputs: they follow the position one cycle late, which also
  // keeps every anode off during the first cycle after reset releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q    <= SEG_BLANK;
      anodo_q  <= AN_OFF;
      quadro_q <= 1'b0;
    end else begin
      seg_q    <= seg_next;
      anodo_q  <= anodo_next;
      quadro_q <= fim_varredura;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.anodo  = anodo_q;
  assign bus.quadro = quadro_q;

endmodule
